// File: rtl/branch_resolve_unit.sv
// Branch resolution: compares complex-ALU control results with dispatch-time predictions,
// drives fetch redirect / predictor update, and queues every accepted result for the CDB.
module branch_resolve_unit #(
   parameter int unsigned ROB_W    = 6,
   parameter int unsigned PHYS_W   = 7,
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_wr_i,
   input  logic [ROB_W-1:0]  pred_rob_id_i,
   input  logic [31:0]       pred_pc_i,
   input  logic              pred_taken_i,
   input  logic [31:0]       pred_target_i,
   input  logic              alu_valid_i,
   input  logic [31:0]       alu_result_i,
   input  logic [31:0]       alu_target_i,
   input  logic              alu_taken_i,
   input  logic [ROB_W-1:0]  alu_rob_id_i,
   input  logic [PHYS_W-1:0] alu_phys_dest_i,
   input  logic              alu_exception_i,
   input  logic [ROB_W-1:0]  rob_head_i,
   input  logic              recover_done_i,
   input  logic              flush_i,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [31:0]       wb_data_o,
   output logic [ROB_W-1:0]  wb_rob_id_o,
   output logic [PHYS_W-1:0] wb_phys_dest_o,
   output logic              wb_mispredict_o,
   output logic              wb_exception_o,
   output logic              redirect_valid_o,
   output logic [31:0]       redirect_pc_o,
   output logic              bp_upd_valid_o,
   output logic [31:0]       bp_upd_pc_o,
   output logic              bp_upd_taken_o,
   output logic [31:0]       bp_upd_target_o,
   output logic              almost_full_o,
   output logic              overflow_o
);

   localparam int unsigned NumEnt = 1 << ROB_W;
   localparam int unsigned PtrW   = $clog2(WB_DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(WB_DEPTH);
   localparam logic [CntW-1:0] AfThr  = CntW'(WB_DEPTH - 2);

   typedef enum logic [0:0] {StIdle, StRecover} state_e;

   typedef struct packed {
      logic [31:0]       data;
      logic [ROB_W-1:0]  rob;
      logic [PHYS_W-1:0] phys;
      logic              mis;
      logic              exc;
   } wb_ent_t;

   state_e             state_q, state_d;
   logic [ROB_W-1:0]   sq_q, sq_d;
   logic [NumEnt-1:0]  pv_q;
   logic [NumEnt-1:0]  ptaken_q;
   logic [31:0]        ppc_q  [NumEnt];
   logic [31:0]        ptgt_q [NumEnt];

   wb_ent_t            mem_q [WB_DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]    cnt_q;
   logic               ovf_q;

   logic               rv_q, bv_q, btk_q;
   logic [31:0]        rpc_q, bpc_q, btgt_q;

   logic               res_v, hit, younger, accept, exc, mispred, ctrl_ok, redir, clr_en;
   logic               deq, full, enq, ovf_set;
   logic [ROB_W-1:0]   age_res, age_sq;
   logic [31:0]        e_pc, e_tgt, act_pc;
   logic               e_taken;
   wb_ent_t            new_ent;

   always_comb begin
      res_v   = alu_valid_i && !flush_i;
      hit     = pv_q[alu_rob_id_i];
      e_pc    = ppc_q[alu_rob_id_i];
      e_tgt   = ptgt_q[alu_rob_id_i];
      e_taken = ptaken_q[alu_rob_id_i];
      age_res = alu_rob_id_i - rob_head_i;
      age_sq  = sq_q - rob_head_i;
      younger = (state_q == StRecover) && (age_res > age_sq);
      accept  = res_v && !younger;
      // Misaligned taken target only matters for real control ops
      exc     = alu_exception_i || (hit && alu_taken_i && (alu_target_i[1:0] != 2'b00));
      act_pc  = alu_taken_i ? alu_target_i : e_pc + 32'd4;
      mispred = hit && ((alu_taken_i != e_taken) || (alu_taken_i && (alu_target_i != e_tgt)));
      ctrl_ok = accept && hit && !exc;
      redir   = ctrl_ok && mispred;
      clr_en  = res_v && hit;

      deq     = (cnt_q != '0) && wb_ready_i;
      full    = (cnt_q == DepthC);
      enq     = accept && (!full || deq);
      ovf_set = accept && full && !deq;

      new_ent.data = alu_result_i;
      new_ent.rob  = alu_rob_id_i;
      new_ent.phys = alu_phys_dest_i;
      new_ent.mis  = mispred && !exc;
      new_ent.exc  = exc;
   end

   always_comb begin
      state_d = state_q;
      sq_d    = sq_q;
      unique case (state_q)
         StIdle: begin
            if (redir) begin
               state_d = StRecover;
               sq_d    = alu_rob_id_i;
            end
         end
         StRecover: begin
            // A fresh older mispredict restarts recovery even if the old one just finished
            if (redir) sq_d = alu_rob_id_i;
            else if (recover_done_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush_i) state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sq_q    <= '0;
      end else begin
         state_q <= state_d;
         sq_q    <= sq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         pv_q <= '0;
      end else begin
         if (clr_en) pv_q[alu_rob_id_i] <= 1'b0;
         if (pred_wr_i) pv_q[pred_rob_id_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (pred_wr_i) begin
         ppc_q[pred_rob_id_i]    <= pred_pc_i;
         ptgt_q[pred_rob_id_i]   <= pred_target_i;
         ptaken_q[pred_rob_id_i] <= pred_taken_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rv_q   <= 1'b0;
         rpc_q  <= '0;
         bv_q   <= 1'b0;
         bpc_q  <= '0;
         btk_q  <= 1'b0;
         btgt_q <= '0;
      end else begin
         rv_q <= redir;
         bv_q <= ctrl_ok;
         if (redir) rpc_q <= act_pc;
         if (ctrl_ok) begin
            bpc_q  <= e_pc;
            btk_q  <= alu_taken_i;
            btgt_q <= alu_target_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (enq && !deq) cnt_q <= cnt_q + 1'b1;
         else if (!enq && deq) cnt_q <= cnt_q - 1'b1;
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !flush_i && !rst) mem_q[wr_ptr_q] <= new_ent;
   end

   always_comb begin
      wb_valid_o      = (cnt_q != '0);
      wb_data_o       = wb_valid_o ? mem_q[rd_ptr_q].data : '0;
      wb_rob_id_o     = wb_valid_o ? mem_q[rd_ptr_q].rob  : '0;
      wb_phys_dest_o  = wb_valid_o ? mem_q[rd_ptr_q].phys : '0;
      wb_mispredict_o = wb_valid_o && mem_q[rd_ptr_q].mis;
      wb_exception_o  = wb_valid_o && mem_q[rd_ptr_q].exc;
      almost_full_o   = (cnt_q >= AfThr);
      overflow_o      = ovf_q;
      redirect_valid_o = rv_q;
      redirect_pc_o    = rpc_q;
      bp_upd_valid_o   = bv_q;
      bp_upd_pc_o      = bpc_q;
      bp_upd_taken_o   = btk_q;
      bp_upd_target_o  = btgt_q;
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of prediction table, recovery and writeback queue.
module tb_branch_resolve_unit;

   localparam int ROB_W  = 6;
   localparam int PHYS_W = 7;
   localparam int DEPTH  = 4;
   localparam int NENT   = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, pred_wr_i, pred_taken_i, alu_valid_i, alu_taken_i, alu_exception_i;
   logic [ROB_W-1:0]  pred_rob_id_i, alu_rob_id_i, rob_head_i, wb_rob_id_o;
   logic [31:0]       pred_pc_i, pred_target_i, alu_result_i, alu_target_i;
   logic [PHYS_W-1:0] alu_phys_dest_i, wb_phys_dest_o;
   logic              recover_done_i, flush_i, wb_valid_o, wb_ready_i;
   logic [31:0]       wb_data_o, redirect_pc_o, bp_upd_pc_o, bp_upd_target_o;
   logic              wb_mispredict_o, wb_exception_o, redirect_valid_o, bp_upd_valid_o;
   logic              bp_upd_taken_o, almost_full_o, overflow_o;

   branch_resolve_unit #(.ROB_W(ROB_W), .PHYS_W(PHYS_W), .WB_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .pred_wr_i(pred_wr_i), .pred_rob_id_i(pred_rob_id_i), .pred_pc_i(pred_pc_i),
      .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i), .alu_target_i(alu_target_i),
      .alu_taken_i(alu_taken_i), .alu_rob_id_i(alu_rob_id_i), .alu_phys_dest_i(alu_phys_dest_i),
      .alu_exception_i(alu_exception_i), .rob_head_i(rob_head_i),
      .recover_done_i(recover_done_i), .flush_i(flush_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
      .wb_rob_id_o(wb_rob_id_o), .wb_phys_dest_o(wb_phys_dest_o),
      .wb_mispredict_o(wb_mispredict_o), .wb_exception_o(wb_exception_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .bp_upd_valid_o(bp_upd_valid_o), .bp_upd_pc_o(bp_upd_pc_o),
      .bp_upd_taken_o(bp_upd_taken_o), .bp_upd_target_o(bp_upd_target_o),
      .almost_full_o(almost_full_o), .overflow_o(overflow_o)
   );

   typedef struct {
      logic [31:0] data;
      int          rob;
      int          phys;
      bit          mis;
      bit          exc;
   } wb_t;

   wb_t wb_q[$];
   int  checks = 0;
   int  failures = 0;
   bit  mon_en = 0;

   // Per-cycle stimulus; s_ready and s_head persist across cycles
   bit          s_rst, s_pwr, s_ptk, s_alu_v, s_atk, s_aexc, s_done, s_flush, s_ready;
   int          s_pid, s_aid, s_phys, s_head;
   logic [31:0] s_ppc, s_ptgt, s_ares, s_atgt;

   // Reference model
   bit          m_v [NENT];
   bit          m_tk[NENT];
   logic [31:0] m_pc[NENT];
   logic [31:0] m_tgt[NENT];
   bit          m_rec;
   int          m_sq;
   bit          r_rv, r_bv, r_btk, r_ovf;
   logic [31:0] r_rpc, r_bpc, r_btgt;

   // Expected values for the current cycle, snapshotted before the model advances
   bit          e_rv, e_bv, e_btk, e_ovf;
   logic [31:0] e_rpc, e_bpc, e_btgt;
   int          e_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) m_v[i] = 0;
      wb_q.delete();
      m_rec = 0; m_sq = 0;
      r_rv = 0; r_bv = 0; r_btk = 0; r_ovf = 0;
      r_rpc = '0; r_bpc = '0; r_btgt = '0;
   endtask

   task automatic model_step();
      bit deq, hit, drop, exc, mis, redirected, ptk;
      int age_r, age_sq;
      logic [31:0] ppc, ptgt, actual;
      if (s_rst) begin
         model_reset();
         return;
      end
      if (s_flush) begin
         for (int i = 0; i < NENT; i++) m_v[i] = 0;
         wb_q.delete();
         m_rec = 0; r_rv = 0; r_bv = 0;
         return;
      end
      deq = (wb_q.size() > 0) && s_ready;
      redirected = 0;
      r_rv = 0; r_bv = 0;
      if (s_alu_v) begin
         hit = m_v[s_aid]; ppc = m_pc[s_aid]; ptk = m_tk[s_aid]; ptgt = m_tgt[s_aid];
         m_v[s_aid] = 0;
         age_r  = (s_aid - s_head + NENT) % NENT;
         age_sq = (m_sq - s_head + NENT) % NENT;
         drop = m_rec && (age_r > age_sq);
         if (!drop) begin
            exc = s_aexc || (hit && s_atk && (s_atgt % 4 != 0));
            mis = 0;
            if (hit && !exc) begin
               actual = s_atk ? s_atgt : ppc + 32'd4;
               mis = (s_atk != ptk) || (s_atk && ptk && s_atgt != ptgt);
               r_bv = 1; r_bpc = ppc; r_btk = s_atk; r_btgt = s_atgt;
               if (mis) begin
                  r_rv = 1; r_rpc = actual; m_rec = 1; m_sq = s_aid; redirected = 1;
               end
            end
            if (wb_q.size() == DEPTH && !deq) r_ovf = 1;
            else wb_q.push_back('{data: s_ares, rob: s_aid, phys: s_phys, mis: mis, exc: exc});
         end
      end
      if (!redirected && s_done) m_rec = 0;
      if (s_pwr) begin
         m_v[s_pid] = 1; m_pc[s_pid] = s_ppc; m_tk[s_pid] = s_ptk; m_tgt[s_pid] = s_ptgt;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e_rv = r_rv; e_rpc = r_rpc; e_bv = r_bv; e_bpc = r_bpc; e_btk = r_btk;
      e_btgt = r_btgt; e_ovf = r_ovf; e_cnt = wb_q.size();
      rst = s_rst; pred_wr_i = s_pwr; pred_rob_id_i = ROB_W'(s_pid); pred_pc_i = s_ppc;
      pred_taken_i = s_ptk; pred_target_i = s_ptgt; alu_valid_i = s_alu_v;
      alu_result_i = s_ares; alu_target_i = s_atgt; alu_taken_i = s_atk;
      alu_rob_id_i = ROB_W'(s_aid); alu_phys_dest_i = PHYS_W'(s_phys);
      alu_exception_i = s_aexc; rob_head_i = ROB_W'(s_head); recover_done_i = s_done;
      flush_i = s_flush; wb_ready_i = s_ready;
      model_step();
      s_rst = 0; s_pwr = 0; s_alu_v = 0; s_aexc = 0; s_done = 0; s_flush = 0;
   endtask

   task automatic pred(input int id, input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
      s_pwr = 1; s_pid = id; s_ppc = pc; s_ptk = tk; s_ptgt = tgt;
   endtask

   task automatic alu(input int id, input bit tk, input logic [31:0] tgt, input logic [31:0] res);
      s_alu_v = 1; s_aid = id; s_atk = tk; s_atgt = tgt; s_ares = res; s_phys = id + 1;
   endtask

   // Monitor: compares registered outputs every cycle and pops the scoreboard on each CDB handshake
   always @(negedge clk) begin
      if (mon_en) begin
         chk("redirect_valid", 32'(redirect_valid_o), 32'(e_rv));
         chk("redirect_pc", redirect_pc_o, e_rpc);
         chk("bp_upd_valid", 32'(bp_upd_valid_o), 32'(e_bv));
         chk("bp_upd_pc", bp_upd_pc_o, e_bpc);
         chk("bp_upd_taken", 32'(bp_upd_taken_o), 32'(e_btk));
         chk("bp_upd_target", bp_upd_target_o, e_btgt);
         chk("overflow", 32'(overflow_o), 32'(e_ovf));
         chk("almost_full", 32'(almost_full_o), 32'(e_cnt >= DEPTH - 2));
         chk("wb_valid", 32'(wb_valid_o), 32'(e_cnt != 0));
         if (wb_valid_o && wb_ready_i && !rst && !flush_i) begin
            if (wb_q.size() == 0) begin
               chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
            end else begin
               wb_t x;
               x = wb_q.pop_front();
               chk("wb_data", wb_data_o, x.data);
               chk("wb_rob_id", 32'(wb_rob_id_o), 32'(x.rob));
               chk("wb_phys_dest", 32'(wb_phys_dest_o), 32'(x.phys));
               chk("wb_mispredict", 32'(wb_mispredict_o), 32'(x.mis));
               chk("wb_exception", 32'(wb_exception_o), 32'(x.exc));
            end
         end
      end
   end

   initial begin
      s_ready = 1; s_head = 0; s_ppc = '0; s_ptgt = '0; s_ptk = 0; s_pid = 0;
      s_aid = 0; s_atk = 0; s_atgt = '0; s_ares = '0; s_phys = 0;
      model_reset();
      s_rst = 1; tick();
      mon_en = 1;
      s_rst = 1; tick();
      tick();
      chk("rst_redirect_valid", 32'(redirect_valid_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);

      // BEQ predicted not-taken, resolves taken
      pred(5, 32'h100, 0, 32'h104); tick();
      alu(5, 1, 32'h140, 32'h0); tick();
      tick();
      chk("beq_redirect", 32'(redirect_valid_o), 32'd1);
      chk("beq_redirect_pc", redirect_pc_o, 32'h140);
      chk("beq_upd_taken", 32'(bp_upd_taken_o), 32'd1);
      chk("beq_wb_mispredict", 32'(wb_mispredict_o && wb_valid_o), 32'd1);
      s_done = 1; tick();

      // Predicted taken, resolves not-taken; then a correctly predicted JAL
      pred(3, 32'h80, 1, 32'h200); tick();
      alu(3, 0, 32'h200, 32'h0); tick();
      tick();
      chk("nt_redirect_pc", redirect_pc_o, 32'h84);
      s_done = 1; tick();
      pred(4, 32'h90, 1, 32'h300); tick();
      alu(4, 1, 32'h300, 32'h94); tick();
      tick();
      chk("jal_no_redirect", 32'(redirect_valid_o), 32'd0);
      chk("jal_upd_valid", 32'(bp_upd_valid_o), 32'd1);
      chk("jal_upd_target", bp_upd_target_o, 32'h300);

      // Recovery: 10 mispredicts, 12 dropped, 7 re-redirects, 9 dropped against sq_id 7
      pred(10, 32'h400, 0, 32'h404); tick();
      pred(12, 32'h500, 0, 32'h504); tick();
      pred(7, 32'h600, 0, 32'h604); tick();
      alu(10, 1, 32'h440, 32'h0); tick();
      alu(12, 1, 32'h540, 32'h0); tick();
      alu(7, 1, 32'h640, 32'h0); tick();
      chk("drop_no_upd", 32'(bp_upd_valid_o), 32'd0);
      alu(9, 0, 32'h0, 32'h999); tick();
      chk("older_redirect_pc", redirect_pc_o, 32'h640);
      s_done = 1; tick();
      tick();

      // LUI with no table entry
      alu(20, 0, 32'h0, 32'h12345000); tick();
      tick();
      chk("lui_wb_data", wb_data_o, 32'h12345000);
      chk("lui_no_upd", 32'(bp_upd_valid_o), 32'd0);
      tick();

      // Backpressure: fill, overflow, flush
      s_ready = 0;
      for (int i = 0; i < 5; i++) begin
         alu(21 + i, 0, 32'h0, 32'(32'hA000 + i)); tick();
         if (i == 2) chk("af_at_two", 32'(almost_full_o), 32'd1);
      end
      tick();
      chk("overflow_set", 32'(overflow_o), 32'd1);
      s_flush = 1; tick();
      tick();
      chk("flush_empty", 32'(wb_valid_o), 32'd0);
      chk("flush_keeps_ovf", 32'(overflow_o), 32'd1);
      s_ready = 1;

      // Misaligned taken JALR target
      pred(30, 32'h700, 1, 32'h102); tick();
      alu(30, 1, 32'h102, 32'h704); tick();
      tick();
      chk("jalr_exc", 32'(wb_exception_o && wb_valid_o), 32'd1);
      chk("jalr_no_redirect", 32'(redirect_valid_o), 32'd0);

      // Reset while recovering, then a younger mispredict must redirect from IDLE
      pred(31, 32'h800, 0, 32'h804); tick();
      alu(31, 1, 32'h840, 32'h0); tick();
      s_rst = 1; tick();
      tick();
      chk("rst_rv", 32'(redirect_valid_o), 32'd0);
      chk("rst_rpc", redirect_pc_o, 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      pred(40, 32'h900, 0, 32'h904); tick();
      alu(40, 1, 32'h940, 32'h0); tick();
      tick();
      chk("post_rst_redirect", 32'(redirect_valid_o), 32'd1);
      s_done = 1; tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0)
            pred($urandom_range(0, 15), $urandom & 32'hFFFC, 1'($urandom),
                 ($urandom_range(0, 7) << 4));
         if ($urandom_range(0, 1) == 0) begin
            int id;
            logic [31:0] tgt;
            id  = $urandom_range(0, 15);
            tgt = (m_v[id] && $urandom_range(0, 1) == 0) ? m_tgt[id] : ($urandom_range(0, 7) << 4);
            if ($urandom_range(0, 15) == 0) tgt = tgt + 32'd2;
            alu(id, 1'($urandom), tgt, $urandom);
            s_aexc = ($urandom_range(0, 31) == 0);
         end
         s_ready = ($urandom_range(0, 3) != 0);
         s_done  = ($urandom_range(0, 7) == 0);
         s_flush = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 63) == 0) s_head = $urandom_range(0, 15);
         tick();
      end
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumer of the complex ALU result port. Receives the registered branch/jump/LUI/AUIPC results and compares control-flow outcomes against the prediction recorded at dispatch. Emits a single-cycle front-end redirect on mispredict and a predictor-update record. Buffers all results into a writeback FIFO toward the common data bus. Squashes wrong-path results while a recovery is in progress.

## Interface
- `ROB_W`, default 6: ROB id width; the prediction table has 2^ROB_W entries.
- `PHYS_W`, default 7: physical register id width.
- `WB_DEPTH`, default 4: writeback FIFO depth; must be a power of two and ≥ 4.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pred_wr_i` in 1: record a prediction for a dispatched JAL/JALR/branch.
- `pred_rob_id_i` in ROB_W: ROB id of the recorded control op.
- `pred_pc_i` in 32: PC of the control op.
- `pred_taken_i` in 1: predicted direction.
- `pred_target_i` in 32: predicted target.
- `alu_valid_i` in 1: complex ALU result valid. The ALU cannot be stalled, so every valid result must be accepted.
- `alu_result_i` in 32: ALU result value.
- `alu_target_i` in 32: resolved branch/jump target.
- `alu_taken_i` in 1: resolved direction.
- `alu_rob_id_i` in ROB_W: ROB id of the result.
- `alu_phys_dest_i` in PHYS_W: physical destination of the result.
- `alu_exception_i` in 1: exception reported by the ALU.
- `rob_head_i` in ROB_W: oldest in-flight ROB id, used for age comparison.
- `recover_done_i` in 1: front end and rename have finished squashing.
- `flush_i` in 1: global pipeline flush from commit.
- `wb_valid_o` out 1: head of the writeback FIFO is valid.
- `wb_ready_i` in 1: CDB accepts the FIFO head.
- `wb_data_o` out 32: writeback data.
- `wb_rob_id_o` out ROB_W: writeback ROB id.
- `wb_phys_dest_o` out PHYS_W: writeback physical destination.
- `wb_mispredict_o` out 1: writeback entry was mispredicted.
- `wb_exception_o` out 1: writeback entry carries an exception.
- `redirect_valid_o` out 1: single-cycle redirect pulse to fetch.
- `redirect_pc_o` out 32: corrected fetch PC.
- `bp_upd_valid_o` out 1: predictor update valid.
- `bp_upd_pc_o` out 32: PC of the resolved control op.
- `bp_upd_taken_o` out 1: resolved direction.
- `bp_upd_target_o` out 32: resolved target.
- `almost_full_o` out 1: issue must stop sending complex ALU ops.
- `overflow_o` out 1: sticky; a result was dropped because the FIFO was full.

## Operation
- **Prediction table:** one entry per ROB id holding {valid, pc, taken, target}.
  - `pred_wr_i` sets the entry's valid bit and stores its fields.
  - A resolved lookup clears the valid bit.
  - If a write and a clear hit the same id in the same cycle, the write wins.
- **Entry classification:** an `alu_valid_i` whose table entry is valid is a control op. An entry that is not valid means a plain result (LUI/AUIPC): it is written back only, with no compare and no predictor update.
- **Control op compare:**
  - Actual PC is `alu_target_i` if taken, else `pc + 4` (32-bit wrap).
  - Mispredict occurs when taken differs from predicted taken, or when both are taken and the targets differ.
  - If taken and `alu_target_i[1:0] != 0`, or if `alu_exception_i` is set: write back with the exception flag, no redirect, no predictor update.
- **Age:** computed as `(id − rob_head_i) mod 2^ROB_W`; a smaller value means older.
- **FSM with states IDLE and RECOVER:**
  - **IDLE:** a mispredict pulses the redirect, captures `sq_id` = ROB id, and moves to RECOVER.
  - **RECOVER, younger result:** a result younger than `sq_id` is dropped. It produces no writeback, no update and no redirect, and its table entry is cleared.
  - **RECOVER, older or equal result:** the result is processed normally. An older mispredict pulses the redirect again and replaces `sq_id`.
  - **RECOVER, `recover_done_i`:** returns to IDLE. If `recover_done_i` coincides with a new result, the result is classified in RECOVER first.
- **`flush_i`** has the highest priority. In the same cycle it clears the whole table, empties the FIFO, returns the FSM to IDLE, and discards any concurrent ALU result. It does not clear `overflow_o`.
- **Writeback FIFO:**
  - Enqueue on each accepted result; dequeue when `wb_valid_o && wb_ready_i`.
  - Simultaneous enqueue and dequeue is allowed when full.
  - Enqueue while full without a dequeue drops the result and sets `overflow_o`.
  - `almost_full_o` = count ≥ WB_DEPTH−2, which covers the two results already in flight.

## Timing
- ALU result sampled in cycle N → `redirect_valid_o` and `bp_upd_*` are registered and high in cycle N+1 for exactly one cycle.
- The FIFO entry is visible on `wb_*` in N+1 at the earliest, when the FIFO was empty.
- Redirect/update outputs hold their last values while their valid signal is low.
- `wb_*` fields are only meaningful while `wb_valid_o` is high.
- **Reset:** all outputs are 0, the FIFO is empty, the FSM is in IDLE, all table valid bits are clear, and `overflow_o` is 0.
- The FIFO head is stable while `wb_valid_o && !wb_ready_i`.
- FIFO pointers wrap modulo WB_DEPTH.

## Test plan
- Predict BEQ at pc `0x100` not-taken (rob 5), ALU taken with target `0x140` → N+1: `redirect_valid_o`=1 with `redirect_pc_o`=`0x140`; wb entry has mispredict=1; `bp_upd_taken_o`=1.
- Predict taken to `0x200` at pc `0x80` (rob 3), ALU not-taken → redirect to `0x84`. Then a correctly predicted JAL with target `0x300` → no redirect, update only.
- Head=0: mispredict rob 10 → RECOVER. Then a result for rob 12 → dropped, nothing written back. Then a mispredict for rob 7 → second redirect with `sq_id`=7. Then `recover_done_i` → IDLE.
- LUI result `0x12345000` with no table entry → wb data `0x12345000`, no redirect, no update.
- Hold `wb_ready_i`=0 with WB_DEPTH=4 and stream results → `almost_full_o` rises at count 2; the 5th result sets `overflow_o`; `flush_i` empties the FIFO and `overflow_o` stays 1.
- Taken JALR with target `0x102` → `wb_exception_o`=1, no redirect. Assert `rst` mid-RECOVER → all outputs 0 and the FSM returns to IDLE next cycle.
